fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer between the PC and a variable-latency instruction memory port.
//  Issues one word request at a time, holds the returned word until decode accepts it, then advances the PC.
//  Handles branch/exception redirects, including squashing in-flight responses.
//  Sits between the core's decode stage and the imem (or an arbiter in front of it).
// PARAMETERS
//  LENGTH    32     data/PC width in bits
//  SEL_BITS  10     memory word-address width (SIZE = 2**SEL_BITS words)
//  RESET_PC  32'h0  byte address fetched first after reset
// PORTS
//  clk             in   1         clock; all state updates on rising edge
//  reset           in   1         synchronous, active-high reset
//  redirect_valid  in   1         load new PC this cycle (branch/exception)
//  redirect_pc     in   LENGTH    byte address of redirect target
//  mem_req         out  1         request valid toward memory
//  mem_addr        out  SEL_BITS  word address = pc[SEL_BITS+1:2]
//  mem_gnt         in   1         memory accepts request (handshake: mem_req & mem_gnt)
//  mem_rvalid      in   1         response valid, >=1 cycle after grant
//  mem_rdata       in   LENGTH    response instruction word
//  if_valid        out  1         instruction available to decode
//  if_ready        in   1         decode accepts (transfer: if_valid & if_ready)
//  if_ins          out  LENGTH    buffered instruction
//  if_pc           out  LENGTH    byte PC of if_ins
// BEHAVIOUR
//  Reset: state=REQ, pc=RESET_PC & ~3, if_valid=0, if_ins=0, if_pc=0; mem_req=1 from first cycle after reset.
//  All outputs registered or decoded from state only; no comb path from inputs to outputs.
//  States:
//   REQ   mem_req=1, mem_addr from pc.
//         - mem_gnt -> WAIT.
//         - redirect without gnt -> pc<=redirect_pc, stay REQ (ungranted addr may change).
//         - redirect with gnt -> pc<=redirect_pc, FLUSH.
//   WAIT  mem_req=0.
//         - mem_rvalid -> if_ins<=mem_rdata, if_pc<=pc, if_valid<=1, HOLD.
//         - redirect (with or without rvalid) -> pc<=redirect_pc; rvalid same cycle: data dropped, REQ; else FLUSH.
//   FLUSH mem_req=0; wait mem_rvalid, discard data, -> REQ. Further redirects here only update pc.
//   HOLD  if_valid=1, if_ins/if_pc stable.
//         - transfer -> if_valid<=0, pc<=pc+4, REQ.
//         - redirect -> if_valid<=0, pc<=redirect_pc, REQ. With a same-cycle transfer the word still counts as
//           delivered; decode kills it.
//  Priority in every state: reset > redirect > memory/decode events.
//  redirect_pc[1:0] ignored (forced 0). pc+4 wraps modulo 2**LENGTH. mem_addr drops bits above SEL_BITS+1 (aliasing).
//  mem_rvalid outside WAIT/FLUSH is a protocol error: ignored; assertion fires in simulation.
//  At most one outstanding request. Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with 1-cycle memory.
//  Reset mid-transaction: state/pc/outputs reinitialised next edge; memory must also be reset (no late rvalid).
// STRUCTURE
//  fetch_pkg: typedef enum logic [1:0] {REQ, WAIT, FLUSH, HOLD} fetch_state_t; localparam INSN_BYTES = 4.
//  Sub-module fetch_buf: if_ins/if_pc/if_valid holding register with load/clear controls.
//  FSM, PC and next-PC logic stay in fetch_ctrl.
// TESTING
//  1. Reset, 1-cycle memory, if_ready=1 -> mem_addr 0,1,2,3; if_pc 0x0,0x4,0x8,0xC; one transfer per 3 cycles.
//  2. mem_gnt low 4 cycles -> mem_req held, mem_addr stable at 0, no if_valid until grant + rvalid.
//  3. if_ready=0 for 5 cycles in HOLD -> if_ins/if_pc unchanged, mem_req=0 throughout; pc advances by 4 on release.
//  4. redirect 0x100 in WAIT, rvalid 3 cycles later with 0xDEAD -> 0xDEAD never on if_ins; next mem_addr=0x40,
//     if_pc=0x100.
//  5. redirect 0x203 in REQ without gnt -> mem_addr switches to 0x80 next cycle; no FLUSH entered.
//  6. redirect_pc=0xFFFFFFFC, then sequential fetch -> next if_pc=0x0 (wrap). reset asserted in FLUSH ->
//     next fetch at RESET_PC, if_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam int INSN_BYTES = 4;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - holding register for the fetched instruction, its PC and valid flag
module fetch_buf #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [LENGTH-1:0] ins_d,
  input  logic [LENGTH-1:0] pc_d,
  output logic              valid,
  output logic [LENGTH-1:0] ins,
  output logic [LENGTH-1:0] pc
);

  // clear only drops valid; ins/pc keep their last value
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ins   <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ins   <= ins_d;
      pc    <= pc_d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch sequencer with redirect and squash
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                LENGTH   = 32,
  parameter int                SEL_BITS = 10,
  parameter logic [LENGTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [LENGTH-1:0]   redirect_pc,
  output logic                mem_req,
  output logic [SEL_BITS-1:0] mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [LENGTH-1:0]   mem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [LENGTH-1:0]   if_ins,
  output logic [LENGTH-1:0]   if_pc
);

  localparam logic [LENGTH-1:0] ALIGN_MASK = ~LENGTH'(INSN_BYTES - 1);

  fetch_state_t      state, state_n;
  logic [LENGTH-1:0] pc, pc_n;
  logic [LENGTH-1:0] redir_pc;
  logic              buf_load, buf_clear;

  assign redir_pc = redirect_pc & ALIGN_MASK;
  assign mem_req  = (state == REQ);
  assign mem_addr = pc[SEL_BITS+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc    <= RESET_PC & ALIGN_MASK;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // redirect outranks memory and decode events in every state
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_n    = redir_pc;
          state_n = mem_gnt ? FLUSH : REQ;
        end else if (mem_gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n    = redir_pc;
          state_n = mem_rvalid ? REQ : FLUSH;
        end else if (mem_rvalid) begin
          buf_load = 1'b1;
          state_n  = HOLD;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_n = redir_pc;
        if (mem_rvalid) state_n = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          buf_clear = 1'b1;
          pc_n      = redir_pc;
          state_n   = REQ;
        end else if (if_ready) begin
          buf_clear = 1'b1;
          pc_n      = pc + LENGTH'(INSN_BYTES);
          state_n   = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  fetch_buf #(
    .LENGTH(LENGTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .ins_d (mem_rdata),
    .pc_d  (pc),
    .valid (if_valid),
    .ins   (if_ins),
    .pc    (if_pc)
  );

  // a response is only legal while a request is outstanding
  a_rvalid_legal: assert property (@(posedge clk) disable iff (reset)
    mem_rvalid |-> (state == WAIT || state == FLUSH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard bench for fetch_ctrl with a variable-latency memory model
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ins;
  logic [31:0] if_pc;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic [9:0] gnt_log[$];

  logic gnt_en = 1'b0;
  int   lat = 1;
  int   dead_req = 0;
  logic chk_rate = 1'b0;

  fetch_ctrl #(
    .LENGTH(32),
    .SEL_BITS(10),
    .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ins         (if_ins),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return 32'hA500_0000 | {22'b0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory: grants on request when enabled, answers lat cycles after the grant
  initial begin
    int         pend;
    int         dead_done;
    logic [9:0] pend_addr;
    pend = 0;
    dead_done = 0;
    pend_addr = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (reset) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid = 1'b1;
          if (dead_req != dead_done) begin
            mem_rdata = 32'h0000_DEAD;
            dead_done++;
          end else begin
            mem_rdata = mem_word(pend_addr);
          end
        end
      end
      mem_gnt = gnt_en && !reset;
      if (mem_gnt && mem_req) begin
        pend = lat;
        pend_addr = mem_addr;
        gnt_log.push_back(mem_addr);
      end
    end
  end

  // decode side: every transfer is checked against the scoreboard
  initial begin
    int   neg_n;
    int   prev;
    exp_t e;
    neg_n = 0;
    prev = -1;
    forever begin
      @(negedge clk);
      neg_n++;
      if (!chk_rate) prev = -1;
      if (!reset && if_valid && if_ready) begin
        chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("xfer_pc", if_pc, e.pc);
          chk("xfer_ins", if_ins, e.ins);
        end
        if (chk_rate) begin
          if (prev >= 0) chk("xfer_period", 32'(neg_n - prev), 32'd3);
          prev = neg_n;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) cyc();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_req_low(input string tag, input int max);
    for (int i = 0; i < max && mem_req; i++) cyc();
    chk(tag, 32'(mem_req), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max && !if_valid; i++) cyc();
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_ins"}, if_ins, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  task automatic chk_grants(input string tag, input int base, input logic [9:0] a0,
                            input logic [9:0] a1, input int n);
    chk({tag, "_ngnt"}, 32'(gnt_log.size() - base), 32'(n));
    if (n > 0 && gnt_log.size() > base) chk({tag, "_gnt0"}, 32'(gnt_log[base]), 32'(a0));
    if (n > 1 && gnt_log.size() > base + 1) chk({tag, "_gnt1"}, 32'(gnt_log[base+1]), 32'(a1));
  endtask

  initial begin
    int base;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;

    // reset state, then sequential fetch with 1-cycle memory
    cyc();
    cyc();
    chk_reset_state("rst");
    base = gnt_log.size();
    for (int i = 0; i < 4; i++) push(32'(i * 4), mem_word(10'(i)));
    chk_rate = 1'b1;
    gnt_en = 1'b1;
    reset = 1'b0;
    wait_drain("t1_drain", 30);
    gnt_en = 1'b0;
    chk_rate = 1'b0;
    chk("t1_ngnt", 32'(gnt_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < gnt_log.size()) chk("t1_gnt_addr", 32'(gnt_log[base+i]), 32'(i));

    // grant withheld: request and address held
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    base = gnt_log.size();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_mem_req", 32'(mem_req), 32'd1);
      chk("t2_mem_addr", 32'(mem_addr), 32'd0);
      chk("t2_if_valid", 32'(if_valid), 32'd0);
    end
    push(32'h0, mem_word(10'd0));
    gnt_en = 1'b1;
    wait_drain("t2_drain", 10);
    gnt_en = 1'b0;
    chk_grants("t2", base, 10'd0, 10'd0, 1);

    // decode stall in HOLD
    if_ready = 1'b0;
    push(32'h4, mem_word(10'd1));
    push(32'h8, mem_word(10'd2));
    gnt_en = 1'b1;
    wait_valid("t3_valid", 10);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_if_ins", if_ins, mem_word(10'd1));
      chk("t3_if_pc", if_pc, 32'h4);
      chk("t3_mem_req", 32'(mem_req), 32'd0);
    end
    if_ready = 1'b1;
    wait_drain("t3_drain", 10);
    gnt_en = 1'b0;
    chk("t3_next_addr", 32'(mem_addr), 32'd3);

    // redirect in WAIT; the late 0xDEAD response must be squashed
    base = gnt_log.size();
    lat = 4;
    dead_req++;
    gnt_en = 1'b1;
    wait_req_low("t4_wait", 10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_flush_req", 32'(mem_req), 32'd0);
    chk("t4_flush_addr", 32'(mem_addr), 32'h40);
    chk("t4_flush_valid", 32'(if_valid), 32'd0);
    push(32'h100, mem_word(10'h40));
    wait_drain("t4_drain", 20);
    gnt_en = 1'b0;
    lat = 1;
    chk_grants("t4", base, 10'd3, 10'h40, 2);

    // redirect in REQ without grant: address switches, no flush
    chk("t5_addr_before", 32'(mem_addr), 32'h41);
    base = gnt_log.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    cyc();
    redirect_valid = 1'b0;
    chk("t5_mem_req", 32'(mem_req), 32'd1);
    chk("t5_mem_addr", 32'(mem_addr), 32'h80);
    push(32'h200, mem_word(10'h80));
    gnt_en = 1'b1;
    wait_drain("t5_drain", 10);
    gnt_en = 1'b0;
    chk_grants("t5", base, 10'h80, 10'h0, 1);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("t6_wrap_addr", 32'(mem_addr), 32'h3FF);
    push(32'hFFFF_FFFC, mem_word(10'h3FF));
    push(32'h0, mem_word(10'h0));
    gnt_en = 1'b1;
    wait_drain("t6_drain", 15);
    gnt_en = 1'b0;

    // reset while a squashed response is still outstanding
    lat = 6;
    gnt_en = 1'b1;
    wait_req_low("t6_wait", 10);
    gnt_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    redirect_valid = 1'b0;
    chk("t6_flush_req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    cyc();
    chk_reset_state("t6_rst");
    lat = 1;
    push(32'h0, mem_word(10'h0));
    gnt_en = 1'b1;
    reset = 1'b0;
    wait_drain("t6_post_rst", 10);
    gnt_en = 1'b0;

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
